// File: rtl/cpu_pkg.sv
// cpu_pkg: opcodes, regToMem encodings, fetch states and decode bundles
package cpu_pkg;
  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_MOVI = 4'h8;
  localparam logic [3:0] OP_MOV  = 4'h9;
  localparam logic [3:0] OP_LD   = 4'hA;
  localparam logic [3:0] OP_ST   = 4'hB;
  localparam logic [3:0] OP_JMP  = 4'hC;
  localparam logic [3:0] OP_ILLD = 4'hD;
  localparam logic [3:0] OP_ILLE = 4'hE;
  localparam logic [3:0] OP_HALT = 4'hF;
  localparam logic [1:0] RTM_NONE = 2'b00;
  localparam logic [1:0] RTM_LD   = 2'b01;
  localparam logic [1:0] RTM_ST   = 2'b10;
  typedef enum logic [1:0] {ST_RESET, ST_REQ, ST_HOLD, ST_HALT} state_t;
  typedef struct packed {
    logic       write;
    logic [3:0] write_reg;
    logic [3:0] read_reg0;
    logic [3:0] read_reg1;
    logic [1:0] reg_to_mem;
    logic       move;
    logic       immediate;
    logic [1:0] quarter;
    logic [3:0] alu_op;
    logic       read_mem;
    logic       write_mem;
  } ctl_t;
  typedef struct packed {
    ctl_t ctl;
    logic jump;
    logic halt;
    logic illegal;
  } dec_t;
endpackage

// File: rtl/instr_decoder.sv
// instr_decoder: combinational 16-bit instruction word to control bundle
module instr_decoder
  import cpu_pkg::*;
(
  input  logic [15:0] instr,
  output dec_t        fields
);
  logic [3:0] op, rd, rs0, rs1;
  assign op  = instr[15:12];
  assign rd  = instr[11:8];
  assign rs0 = instr[7:4];
  assign rs1 = instr[3:0];
  always_comb begin
    fields = '0;
    case (op)
      OP_NOP: ;
      OP_MOVI: begin
        fields.ctl.write     = 1'b1;
        fields.ctl.move      = 1'b1;
        fields.ctl.immediate = 1'b1;
        fields.ctl.write_reg = rd;
        fields.ctl.read_reg0 = rd;
        fields.ctl.quarter   = instr[7:6];
      end
      OP_MOV: begin
        fields.ctl.write     = 1'b1;
        fields.ctl.move      = 1'b1;
        fields.ctl.write_reg = rd;
        fields.ctl.read_reg0 = rs0;
      end
      OP_LD: begin
        fields.ctl.write      = 1'b1;
        fields.ctl.read_mem   = 1'b1;
        fields.ctl.reg_to_mem = RTM_LD;
        fields.ctl.write_reg  = rd;
        fields.ctl.read_reg0  = rs0;
      end
      OP_ST: begin
        fields.ctl.write_mem  = 1'b1;
        fields.ctl.reg_to_mem = RTM_ST;
        fields.ctl.read_reg0  = rs0;
        fields.ctl.read_reg1  = rd;
      end
      OP_JMP: fields.jump = 1'b1;
      OP_HALT: fields.halt = 1'b1;
      OP_ILLD, OP_ILLE: fields.illegal = 1'b1;
      default: begin
        fields.ctl.write     = 1'b1;
        fields.ctl.write_reg = rd;
        fields.ctl.read_reg0 = rs0;
        fields.ctl.read_reg1 = rs1;
        fields.ctl.alu_op    = op;
      end
    endcase
  end
endmodule

// File: rtl/fetch_decode.sv
// fetch_decode: instruction fetch FSM, PC and registered decode into the IF/ID latch
module fetch_decode
  import cpu_pkg::*;
#(
  parameter int              PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [PC_W-1:0] redirect_pc,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [15:0]     imem_data,
  output logic            write,
  output logic [3:0]      writeReg,
  output logic [3:0]      readReg0,
  output logic [3:0]      readReg1,
  output logic [1:0]      regToMem,
  output logic            move,
  output logic            immediate,
  output logic [1:0]      quarter,
  output logic [3:0]      ALU_operation,
  output logic            ReadMem,
  output logic            WriteMem,
  output logic [PC_W-1:0] pc_out,
  output logic            halted,
  output logic            illegal
);
  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d, pc_out_q, pc_out_d;
  logic [15:0]     word_q, word_d, dec_in;
  ctl_t            ctl_q, ctl_d;
  dec_t            dec_w;
  logic            illegal_q, illegal_d, fire;
  assign dec_in = state_q == ST_HOLD ? word_q : imem_data;
  instr_decoder u_dec (.instr(dec_in), .fields(dec_w));
  assign fire = !stall && ((state_q == ST_REQ && imem_ack) || state_q == ST_HOLD);
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    pc_out_d  = pc_out_q;
    word_d    = word_q;
    ctl_d     = ctl_q;
    illegal_d = illegal_q;
    if (redirect_valid) begin
      state_d = ST_REQ;
      pc_d    = redirect_pc;
      ctl_d   = '0;
    end else if (state_q == ST_RESET) begin
      state_d = ST_REQ;
    end else if (state_q == ST_REQ && imem_ack && stall) begin
      word_d  = imem_data;
      state_d = ST_HOLD;
    end else if (fire) begin
      ctl_d     = dec_w.ctl;
      pc_out_d  = pc_q;
      illegal_d = illegal_q | dec_w.illegal;
      state_d   = dec_w.halt ? ST_HALT : ST_REQ;
      pc_d      = dec_w.jump ? pc_q + PC_W'($signed(dec_in[7:0])) :
                  dec_w.halt ? pc_q : pc_q + PC_W'(1);
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_RESET;
      pc_q      <= RESET_PC;
      pc_out_q  <= '0;
      word_q    <= '0;
      ctl_q     <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      pc_out_q  <= pc_out_d;
      word_q    <= word_d;
      ctl_q     <= ctl_d;
      illegal_q <= illegal_d;
    end
  end
  assign imem_req      = state_q == ST_REQ;
  assign imem_addr     = pc_q;
  assign halted        = state_q == ST_HALT;
  assign illegal       = illegal_q;
  assign pc_out        = pc_out_q;
  assign write         = ctl_q.write;
  assign writeReg      = ctl_q.write_reg;
  assign readReg0      = ctl_q.read_reg0;
  assign readReg1      = ctl_q.read_reg1;
  assign regToMem      = ctl_q.reg_to_mem;
  assign move          = ctl_q.move;
  assign immediate     = ctl_q.immediate;
  assign quarter       = ctl_q.quarter;
  assign ALU_operation = ctl_q.alu_op;
  assign ReadMem       = ctl_q.read_mem;
  assign WriteMem      = ctl_q.write_mem;
endmodule
